// File: rtl/rlc_stim_seq.sv
// rlc_stim_seq
// Programmable source-voltage sequencer for the RLC integrator stage.
// A table of N_SEG (level, duration) segments is played out one signed
// fixed-point level per accepted integrator step (valid/ready). The level
// of the previously accepted step is also presented for the RK4 stages.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   cfg_we/addr/level/dur  table write port (ignored while busy)
//   start             begin sequence at entry 0 (IDLE only)
//   abort             stop sequence, return to IDLE, no done pulse
//   step_ready        integrator accepts a step this cycle
//   u_valid, u_out    current source level and its valid flag
//   u_prev_out        level of the previous accepted step
//   seg_idx           active segment
//   step_cnt          accepted steps since start (wraps)
//   busy              sequence running
//   done              one-cycle pulse at sequence end
//
// Build option
//   RLC_STIM_LOOP_EN  when defined, the end of the table wraps back to
//                     entry 0 (done pulses on each wrap) instead of
//                     finishing; only abort or reset leave RUN.
module rlc_stim_seq #(
  parameter int W     = 18,
  parameter int N_SEG = 8,
  parameter int DUR_W = 24
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_we,
  input  logic [$clog2(N_SEG)-1:0] cfg_addr,
  input  logic signed [W-1:0]      cfg_level,
  input  logic [DUR_W-1:0]         cfg_dur,
  input  logic                     start,
  input  logic                     abort,
  input  logic                     step_ready,
  output logic                     u_valid,
  output logic signed [W-1:0]      u_out,
  output logic signed [W-1:0]      u_prev_out,
  output logic [$clog2(N_SEG)-1:0] seg_idx,
  output logic [31:0]              step_cnt,
  output logic                     busy,
  output logic                     done
);

  localparam int AW = $clog2(N_SEG);
  localparam logic [AW-1:0] IDX0 = {AW{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  logic signed [W-1:0] r_level [N_SEG];
  logic [DUR_W-1:0]    r_dur   [N_SEG];

  state_t              r_state;
  logic [DUR_W-1:0]    r_cnt;
  logic                r_u_valid;
  logic signed [W-1:0] r_u_out;
  logic signed [W-1:0] r_u_prev;
  logic [AW-1:0]       r_seg_idx;
  logic [31:0]         r_step_cnt;
  logic                r_busy;
  logic                r_done;

  logic                w_hs;
  logic [AW:0]         w_next_full;
  logic [AW-1:0]       w_next_idx;
  logic                w_seq_end;

  // u_valid is only ever set in RUN, so it doubles as the RUN qualifier.
  assign w_hs        = r_u_valid & step_ready;
  // One extra bit so that running off the last entry is seen as a carry.
  assign w_next_full = {1'b0, r_seg_idx} + {{AW{1'b0}}, 1'b1};
  assign w_next_idx  = w_next_full[AW-1:0];
  assign w_seq_end   = w_next_full[AW] | (r_dur[w_next_idx] == {DUR_W{1'b0}});

  // Segment table: cleared by reset, writable only while not running.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N_SEG; k++) begin
        r_level[k] <= {W{1'b0}};
        r_dur[k]   <= {DUR_W{1'b0}};
      end
    end else if (cfg_we && !r_busy) begin
      r_level[cfg_addr] <= cfg_level;
      r_dur[cfg_addr]   <= cfg_dur;
    end
  end

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= {DUR_W{1'b0}};
      r_u_valid  <= 1'b0;
      r_u_out    <= {W{1'b0}};
      r_u_prev   <= {W{1'b0}};
      r_seg_idx  <= {AW{1'b0}};
      r_step_cnt <= 32'd0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            // Reads the table before any same-cycle write lands.
            if (r_dur[IDX0] == {DUR_W{1'b0}}) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state    <= ST_RUN;
              r_busy     <= 1'b1;
              r_u_valid  <= 1'b1;
              r_seg_idx  <= IDX0;
              r_cnt      <= r_dur[IDX0];
              r_u_out    <= r_level[IDX0];
              r_u_prev   <= {W{1'b0}};
              r_step_cnt <= 32'd0;
            end
          end
        end
        ST_RUN: begin
          if (abort) begin
            // Abort wins over a simultaneous handshake.
            r_state   <= ST_IDLE;
            r_busy    <= 1'b0;
            r_u_valid <= 1'b0;
            r_u_out   <= {W{1'b0}};
          end else if (w_hs) begin
            r_u_prev   <= r_u_out;
            r_step_cnt <= r_step_cnt + 32'd1;
            if (r_cnt != {{(DUR_W-1){1'b0}}, 1'b1}) begin
              r_cnt <= r_cnt - {{(DUR_W-1){1'b0}}, 1'b1};
            end else if (w_seq_end) begin
`ifdef RLC_STIM_LOOP_EN
              r_seg_idx <= IDX0;
              r_cnt     <= r_dur[IDX0];
              r_u_out   <= r_level[IDX0];
              r_done    <= 1'b1;
`else
              r_state   <= ST_DONE;
              r_busy    <= 1'b0;
              r_u_valid <= 1'b0;
              r_done    <= 1'b1;
`endif
            end else begin
              r_seg_idx <= w_next_idx;
              r_cnt     <= r_dur[w_next_idx];
              r_u_out   <= r_level[w_next_idx];
            end
          end
        end
        ST_DONE: begin
          // Both the normal exit and abort land in IDLE; u_prev is kept.
          r_state   <= ST_IDLE;
          r_busy    <= 1'b0;
          r_u_valid <= 1'b0;
          r_u_out   <= {W{1'b0}};
        end
        default: begin
          r_state   <= ST_IDLE;
          r_busy    <= 1'b0;
          r_u_valid <= 1'b0;
          r_u_out   <= {W{1'b0}};
        end
      endcase
    end
  end

  assign u_valid    = r_u_valid;
  assign u_out      = r_u_out;
  assign u_prev_out = r_u_prev;
  assign seg_idx    = r_seg_idx;
  assign step_cnt   = r_step_cnt;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule

// File: tb/tb_rlc_stim_seq.sv
`timescale 1ns/1ps
module tb_rlc_stim_seq;
  localparam int W = 18;
  localparam int N_SEG = 8;
  localparam int DUR_W = 24;
  localparam int AW = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cfg_we = 1'b0;
  logic [AW-1:0] cfg_addr = '0;
  logic signed [W-1:0] cfg_level = '0;
  logic [DUR_W-1:0] cfg_dur = '0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic step_ready = 1'b0;
  logic u_valid;
  logic signed [W-1:0] u_out;
  logic signed [W-1:0] u_prev_out;
  logic [AW-1:0] seg_idx;
  logic [31:0] step_cnt;
  logic busy;
  logic done;

  rlc_stim_seq #(.W(W), .N_SEG(N_SEG), .DUR_W(DUR_W)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_level(cfg_level), .cfg_dur(cfg_dur), .start(start), .abort(abort),
    .step_ready(step_ready), .u_valid(u_valid), .u_out(u_out),
    .u_prev_out(u_prev_out), .seg_idx(seg_idx), .step_cnt(step_cnt),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail = 0;

  // Table contents being programmed and the expected accepted-step stream.
  int m_lvl[N_SEG];
  int m_dur[N_SEG];
  int exp_q[$];
  int seg_q[$];

  typedef struct {
    logic [7:0][31:0]  lvl;
    logic [7:0][31:0]  dur;
    logic [15:0][31:0] eu;
    logic [15:0][31:0] es;
    int n;
    int mode;
  } vec_t;
  vec_t vecs[4];

  task automatic chk(input string nm, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic program_table();
    for (int k = 0; k < N_SEG; k++) begin
      @(negedge clk);
      cfg_we = 1'b1;
      cfg_addr = AW'(k);
      cfg_level = W'(m_lvl[k]);
      cfg_dur = DUR_W'(m_dur[k]);
    end
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  // Reference: the sequence is each segment's level repeated dur times,
  // stopping at the first zero duration or at the end of the table.
  task automatic build_model();
    bit stop;
    stop = 1'b0;
    exp_q.delete();
    seg_q.delete();
    for (int k = 0; k < N_SEG; k++) begin
      if (m_dur[k] == 0) stop = 1'b1;
      if (!stop) begin
        for (int j = 0; j < m_dur[k]; j++) begin
          exp_q.push_back(m_lvl[k]);
          seg_q.push_back(k);
        end
      end
    end
  endtask

  // Runs one full (non-looping) sequence against exp_q/seg_q.
  // mode 0: ready always, 1: ready toggles, 2: random ready.
  task automatic run_seq(input int mode, input bit poke_start);
    int cnt;
    int prev;
    int cyc;
    int rdy;
    int n_exp;
    cnt = 0; prev = 0; cyc = 0; n_exp = exp_q.size();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("start_latency_valid", u_valid, 1);
    chk("start_prev_zero", u_prev_out, 0);
    chk("start_step_cnt", step_cnt, 0);
    while (exp_q.size() > 0 && cyc < 400) begin
      case (mode)
        0: rdy = 1;
        1: rdy = (cyc % 2 == 0) ? 1 : 0;
        default: rdy = int'($urandom_range(0, 1));
      endcase
      step_ready = (rdy != 0);
      start = poke_start ? ($urandom_range(0, 3) == 0) : 1'b0;
      if (u_valid !== 1'b1) begin
        chk("valid_held", u_valid, 1);
        cyc = 400;
      end else if (rdy != 0) begin
        chk("u_out", u_out, exp_q[0]);
        chk("seg_idx", seg_idx, seg_q[0]);
        chk("u_prev_out", u_prev_out, prev);
        chk("step_cnt", step_cnt, cnt);
        prev = exp_q.pop_front();
        void'(seg_q.pop_front());
        cnt++;
      end
      @(negedge clk);
      cyc++;
    end
    step_ready = 1'b0;
    start = 1'b0;
    if (exp_q.size() != 0) chk("seq_timeout", exp_q.size(), 0);
    chk("done_pulse", done, 1);
    chk("busy_end", busy, 0);
    chk("valid_end", u_valid, 0);
    chk("final_step_cnt", step_cnt, n_exp);
    chk("final_prev", u_prev_out, prev);
    @(negedge clk);
    chk("done_single", done, 0);
    chk("u_out_idle", u_out, 0);
    chk("prev_hold", u_prev_out, prev);
  endtask

  task automatic set_basic_table();
    for (int k = 0; k < N_SEG; k++) begin m_lvl[k] = 0; m_dur[k] = 0; end
    m_lvl[0] = 1000; m_dur[0] = 3;
    m_lvl[1] = -500; m_dur[1] = 2;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    int vcnt;
    int ab_exp[4];
    ab_exp[0] = 1000; ab_exp[1] = 1000; ab_exp[2] = 1000; ab_exp[3] = -500;

    // Directed vectors.
    for (int v = 0; v < 4; v++) begin
      vecs[v].lvl = '0; vecs[v].dur = '0; vecs[v].eu = '0; vecs[v].es = '0;
    end
    vecs[0].lvl[0] = 32'sd1000; vecs[0].lvl[1] = -32'sd500;
    vecs[0].dur[0] = 32'd3;     vecs[0].dur[1] = 32'd2;
    vecs[0].eu[0] = 32'sd1000;  vecs[0].eu[1] = 32'sd1000; vecs[0].eu[2] = 32'sd1000;
    vecs[0].eu[3] = -32'sd500;  vecs[0].eu[4] = -32'sd500;
    vecs[0].es[3] = 32'd1;      vecs[0].es[4] = 32'd1;
    vecs[0].n = 5; vecs[0].mode = 0;
    vecs[1] = vecs[0];
    vecs[1].mode = 1;
    for (int k = 0; k < 8; k++) begin
      vecs[2].lvl[k] = 32'(k + 1); vecs[2].dur[k] = 32'd1;
      vecs[2].eu[k] = 32'(k + 1);  vecs[2].es[k] = 32'(k);
    end
    vecs[2].n = 8; vecs[2].mode = 0;
    vecs[3].lvl[0] = -32'sd131072; vecs[3].lvl[1] = 32'sd131071;
    vecs[3].lvl[3] = 32'sd5;
    vecs[3].dur[0] = 32'd1; vecs[3].dur[1] = 32'd2; vecs[3].dur[3] = 32'd4;
    vecs[3].eu[0] = -32'sd131072; vecs[3].eu[1] = 32'sd131071; vecs[3].eu[2] = 32'sd131071;
    vecs[3].es[1] = 32'd1; vecs[3].es[2] = 32'd1;
    vecs[3].n = 3; vecs[3].mode = 2;

    // Reset values.
    repeat (2) @(negedge clk);
    chk("rst_u_valid", u_valid, 0);
    chk("rst_u_out", u_out, 0);
    chk("rst_u_prev", u_prev_out, 0);
    chk("rst_seg_idx", seg_idx, 0);
    chk("rst_step_cnt", step_cnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst = 1'b0;
    @(negedge clk);

`ifndef RLC_STIM_LOOP_EN
    for (int v = 0; v < 4; v++) begin
      for (int k = 0; k < N_SEG; k++) begin
        m_lvl[k] = int'(vecs[v].lvl[k]);
        m_dur[k] = int'(vecs[v].dur[k]);
      end
      program_table();
      exp_q.delete(); seg_q.delete();
      for (int i = 0; i < vecs[v].n; i++) begin
        exp_q.push_back(int'(vecs[v].eu[i]));
        seg_q.push_back(int'(vecs[v].es[i]));
      end
      run_seq(vecs[v].mode, 1'b0);
    end

    // Randomized tables against the reference model.
    for (int it = 0; it < 20; it++) begin
      for (int k = 0; k < N_SEG; k++) begin
        m_lvl[k] = int'($urandom_range(0, 262143)) - 131072;
        if (k == 0) m_dur[k] = int'($urandom_range(1, 3));
        else m_dur[k] = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 3));
      end
      program_table();
      build_model();
      run_seq(2, 1'b1);
    end
`else
    // Looping table: 7,9,7,9,... with done on every wrap.
    for (int k = 0; k < N_SEG; k++) begin m_lvl[k] = 0; m_dur[k] = 0; end
    m_lvl[0] = 7; m_dur[0] = 1; m_lvl[1] = 9; m_dur[1] = 1;
    program_table();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    step_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      chk("loop_u_out", u_out, (i % 2 == 0) ? 7 : 9);
      chk("loop_done", done, (i >= 2 && i % 2 == 0) ? 1 : 0);
      chk("loop_step_cnt", step_cnt, i);
      @(negedge clk);
    end
    abort = 1'b1; step_ready = 1'b0;
    @(negedge clk); abort = 1'b0;
    chk("loop_abort_busy", busy, 0);
    chk("loop_abort_done", done, 0);
    chk("loop_abort_u_out", u_out, 0);
`endif

    // Zero duration at entry 0: straight to DONE, no valid.
    for (int k = 0; k < N_SEG; k++) begin m_lvl[k] = 123; m_dur[k] = 0; end
    program_table();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    pulses = 0; vcnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (done) pulses++;
      if (u_valid || busy) vcnt++;
      @(negedge clk);
    end
    chk("dur0_done_count", pulses, 1);
    chk("dur0_no_valid", vcnt, 0);

    // Abort on the 2nd step of segment 0; cfg write during RUN ignored.
    set_basic_table();
    program_table();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    step_ready = 1'b1;
    cfg_we = 1'b1; cfg_addr = 3'd0; cfg_level = 18'sd777; cfg_dur = 24'd5;
    @(negedge clk);
    cfg_we = 1'b0; abort = 1'b1;
    @(negedge clk);
    abort = 1'b0; step_ready = 1'b0;
    chk("abort_valid", u_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_u_out", u_out, 0);
    chk("abort_step_cnt", step_cnt, 1);
    chk("abort_prev", u_prev_out, 1000);
    chk("abort_no_done", done, 0);
    @(negedge clk);
    chk("abort_no_done_later", done, 0);
    start = 1'b1;
    @(negedge clk); start = 1'b0; step_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("table_unchanged", u_out, ab_exp[i]);
      @(negedge clk);
    end
    abort = 1'b1; step_ready = 1'b0;
    @(negedge clk); abort = 1'b0;
    @(negedge clk);

    // start and cfg_we together: start sees the old entry 0.
    start = 1'b1; cfg_we = 1'b1; cfg_addr = 3'd0; cfg_level = 18'sd55; cfg_dur = 24'd3;
    @(negedge clk); start = 1'b0; cfg_we = 1'b0;
    chk("start_pre_write", u_out, 1000);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("start_post_write", u_out, 55);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    @(negedge clk);

    // Reset mid-RUN: immediate return to reset values, table cleared.
    set_basic_table();
    program_table();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; step_ready = 1'b1;
    @(negedge clk); step_ready = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", u_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_u_out", u_out, 0);
    chk("mid_rst_prev", u_prev_out, 0);
    chk("mid_rst_step_cnt", step_cnt, 0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    pulses = 0; vcnt = 0;
    for (int i = 0; i < 3; i++) begin
      if (done) pulses++;
      if (u_valid) vcnt++;
      @(negedge clk);
    end
    chk("rst_table_cleared_valid", vcnt, 0);
    chk("rst_table_cleared_done", pulses, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rlc_stim_seq.md
# rlc_stim_seq

Programmable source-voltage sequencer feeding the RLC integrator stage, replacing hand-written `initial` stimulus with a synthesizable segment table. Holds up to N_SEG (level, duration) segments, then presents one signed fixed-point source value per integrator step over a valid/ready handshake. Also presents the previous step's value, which the integrator's RK4 stages need. Sits directly upstream of the integrator; one accepted handshake equals one integration step dt.

## Interface
- W, 18, width of signed fixed-point source level (u_out, u_prev_out, cfg_level)
- N_SEG, 8, number of table segments (power of two, ≥2)
- DUR_W, 24, width of segment duration in steps
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- cfg_we  in  1  table write strobe
- cfg_addr  in  $clog2(N_SEG)  table entry to write
- cfg_level  in  W  signed level for entry
- cfg_dur  in  DUR_W  duration in steps for entry; 0 = end-of-sequence marker
- start  in  1  begin sequence at entry 0 (IDLE only)
- abort  in  1  stop sequence immediately
- step_ready  in  1  integrator accepts a step this cycle
- u_valid  out  1  u_out valid for a step
- u_out  out  W  current source level
- u_prev_out  out  W  level of previous accepted step
- seg_idx  out  $clog2(N_SEG)  active segment
- step_cnt  out  32  accepted steps since start, wraps
- busy  out  1  state is RUN
- done  out  1  one-cycle pulse at sequence end

## Operation
- Table: N_SEG entries of flops; reset clears all levels and durations to 0. Writes with cfg_we accepted only when busy=0; ignored in RUN.
- States: IDLE, RUN, DONE.
- IDLE: u_valid=0, u_out=0. On start: if entry 0 dur=0 → DONE; else seg_idx←0, cnt←dur[0], u_out←level[0], u_prev_out←0, step_cnt←0 → RUN.
- RUN: u_valid=1. Step accepted when u_valid && step_ready: u_prev_out←u_out, step_cnt+1. If cnt>1, cnt−1. If cnt=1, advance: next index = seg_idx+1; if next index = N_SEG or dur[next]=0 → end of sequence; else load cnt, u_out from next entry.
- End of sequence (without loop): → DONE.
- DONE: done=1, u_valid=0, u_out←0 on exit; → IDLE next cycle. u_prev_out holds final level until next start.
- abort in RUN or DONE: → IDLE next cycle, u_out←0, no done pulse; abort wins over a simultaneous handshake (step not counted, u_prev_out unchanged).
- start in RUN/DONE ignored. start with cfg_we same cycle (IDLE): start uses pre-write table contents.
- Levels are passed through unmodified; no arithmetic on levels. cnt is DUR_W bits; a loaded cnt is never 0.

## Timing
- All outputs registered. Reset values: u_valid 0, u_out 0, u_prev_out 0, seg_idx 0, step_cnt 0, busy 0, done 0.
- start at edge n → u_valid=1 with level[0] after edge n+1 (one-cycle latency).
- Segment k with dur D holds u_out=level[k] for exactly D accepted steps; next level visible the cycle after the D-th handshake.
- step_ready low stalls: outputs hold, cnt unchanged.
- Last handshake at edge m → done=1 after edge m+1, busy=0 after edge m+1, IDLE after m+2.
- Reset mid-RUN returns to IDLE immediately with reset values and clears the table.

## Configuration
- RLC_STIM_LOOP_EN defined: at end of sequence load entry 0 instead of entering DONE (cnt←dur[0], u_out←level[0]), pulse done for one cycle coincident with the wrap, stay in RUN; only abort or reset exits. step_cnt keeps counting. Sequence with dur[0]=0 still goes start→DONE→IDLE.
- Not defined: sequence runs once, then DONE → IDLE.

## Test plan
- Table {0:(+1000,3),1:(−500,2),2:(0,0)}, step_ready=1, start → u_out 1000,1000,1000,−500,−500 on 5 consecutive valid cycles; done 1 cycle later; step_cnt=5; u_prev_out=−500.
- Same table, step_ready toggling 1/0 → same 5-value sequence over 10 cycles; no value repeated or skipped per accepted step.
- All 8 entries dur=1, levels 1..8 → 8 steps, seg_idx 0..7, done after 8th step (N_SEG boundary, no marker).
- dur[0]=0, start → no u_valid, done pulse 2 cycles after start.
- abort asserted with step_ready on 2nd step of segment 0 → IDLE, no done, step_cnt=1, u_out=0; cfg_we during RUN leaves table unchanged.
- With RLC_STIM_LOOP_EN, table {0:(7,1),1:(9,1),2:(0,0)} → u_out 7,9,7,9,…; done pulses on each wrap; abort ends it.
